// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM modulator fed by a small PCM sample FIFO.
// Each en tick emits one PDM bit; a frame of R bits is produced per sample.
module pdm_modulator #(
    parameter int N     = 16,
    parameter int R     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     run,
    input  logic [N-1:0]             s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     pdm_out,
    output logic                     pdm_valid,
    output logic                     busy,
    output logic                     underrun,
    input  logic                     clr_underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(R);
    localparam logic [N-1:0]  MID  = {1'b1, {(N-1){1'b0}}};
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(R - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_r;
    logic [N-1:0]    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            s_ready_r;
    logic [N-1:0]    acc_r;
    logic [N-1:0]    cur_r;
    logic [PW-1:0]   phase_r;
    logic            hold_r;
    logic            pdm_out_r;
    logic            pdm_valid_r;
    logic            busy_r;
    logic            underrun_r;

    logic            push_s;
    logic            pop_s;
    logic            start_s;
    logic            reload_s;
    logic            frame_end_s;
    logic            set_underrun_s;
    logic [N-1:0]    head_s;
    logic [N-1:0]    u_s;
    logic [N:0]      sum_s;
    logic [PW-1:0]   tick_phase_s;
    logic [LW-1:0]   level_next_s;

    // Next-state decode: frame sequencing, modulator input and FIFO occupancy.
    always_comb begin
        push_s = s_valid & s_ready_r;
        head_s = mem_r[rd_ptr_r];
        if (phase_r == LAST) begin
            tick_phase_s = '0;
        end else begin
            tick_phase_s = phase_r + PW'(1);
        end
        start_s     = (state_r == IDLE) && run && en && (level_r != '0);
        // A fresh sample is loaded on the first tick of a frame unless the previous frame ended empty.
        reload_s    = (state_r == RUN) && en && (tick_phase_s == '0) && !hold_r && (level_r != '0);
        frame_end_s = (state_r == RUN) && en && (tick_phase_s == LAST);
        pop_s       = start_s | reload_s;
        set_underrun_s = frame_end_s && run && (level_r == '0);
        if (pop_s) begin
            u_s = head_s ^ MID;
        end else if (state_r == RUN) begin
            u_s = cur_r ^ MID;
        end else begin
            u_s = MID;
        end
        sum_s = {1'b0, acc_r} + {1'b0, u_s};
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Sample FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            s_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= s_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r   <= level_next_s;
            s_ready_r <= (level_next_s != FULL);
        end
    end

    // Play FSM, accumulator and registered PDM outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cur_r       <= '0;
            phase_r     <= '0;
            hold_r      <= 1'b0;
            pdm_out_r   <= 1'b0;
            pdm_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            if (en) begin
                acc_r       <= sum_s[N-1:0];
                pdm_out_r   <= sum_s[N];
                pdm_valid_r <= 1'b1;
            end else begin
                pdm_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        phase_r <= '0;
                        hold_r  <= 1'b0;
                        cur_r   <= head_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (en) begin
                        phase_r <= tick_phase_s;
                    end else begin
                        phase_r <= phase_r;
                    end
                    if (reload_s) begin
                        cur_r <= head_s;
                    end else begin
                        cur_r <= cur_r;
                    end
                    if (frame_end_s) begin
                        if (!run) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            hold_r  <= (level_r == '0);
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            if (set_underrun_s) begin
                underrun_r <= 1'b1;
            end else if (clr_underrun) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign s_ready    = s_ready_r;
    assign pdm_out    = pdm_out_r;
    assign pdm_valid  = pdm_valid_r;
    assign busy       = busy_r;
    assign underrun   = underrun_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
module tb_pdm_modulator;

    localparam int N     = 16;
    localparam int R     = 10;
    localparam int DEPTH = 4;
    localparam longint HALF = longint'(1) << (N - 1);
    localparam longint FULLSCALE = longint'(1) << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         run;
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         pdm_out;
    logic         pdm_valid;
    logic         busy;
    logic         underrun;
    logic         clr_underrun;
    logic [$clog2(DEPTH):0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queued samples and frame bookkeeping.
    int     q[$];
    bit     playing;
    int     pos;
    int     cur;
    longint acc;
    bit     pending;
    bit     m_pdm;
    bit     m_valid;
    bit     m_und;

    pdm_modulator #(.N(N), .R(R), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .run(run), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .pdm_out(pdm_out), .pdm_valid(pdm_valid), .busy(busy),
        .underrun(underrun), .clr_underrun(clr_underrun), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented for that edge.
    task automatic model_step();
        bit     set_u = 1'b0;
        bit     stop = 1'b0;
        bit     mid = 1'b0;
        int     samp = 0;
        longint u;
        longint tot;
        bit     do_push = s_valid && (q.size() < DEPTH);
        int     pv = $signed(s_data);
        if (rst) begin
            q.delete();
            playing = 1'b0; pos = 0; cur = 0; acc = 0; pending = 1'b0;
            m_pdm = 1'b0; m_valid = 1'b0; m_und = 1'b0;
            return;
        end
        if (en) begin
            if (!playing) begin
                if (run && q.size() > 0) begin
                    cur = q.pop_front();
                    playing = 1'b1;
                    pos = 1;
                    samp = cur;
                end else begin
                    mid = 1'b1;
                end
            end else begin
                if (pos == R) begin
                    pos = 0;
                    if (pending) cur = q.pop_front();
                end
                pos++;
                samp = cur;
                if (pos == R) begin
                    if (!run) stop = 1'b1;
                    else if (q.size() == 0) begin set_u = 1'b1; pending = 1'b0; end
                    else pending = 1'b1;
                end
            end
            u = mid ? HALF : longint'(samp) + HALF;
            tot = acc + u;
            m_pdm = (tot >= FULLSCALE);
            acc = tot % FULLSCALE;
            m_valid = 1'b1;
            if (stop) playing = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        if (set_u) m_und = 1'b1;
        else if (clr_underrun) m_und = 1'b0;
        if (do_push) q.push_back(pv);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pdm_out", 32'(pdm_out), 32'(m_pdm));
        check("pdm_valid", 32'(pdm_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(playing));
        check("underrun", 32'(underrun), 32'(m_und));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("s_ready", 32'(s_ready), 32'(q.size() != DEPTH));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; run = 1'b0; s_valid = 1'b0; clr_underrun = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push(input logic [N-1:0] v);
        s_valid = 1'b1; s_data = v;
        cycle();
        s_valid = 1'b0;
    endtask

    initial begin
        int pat[4];
        logic [N-1:0] vals[5];
        pat = '{0, 1, 1, 1};
        vals = '{16'h1111, 16'h7000, 16'hC000, 16'h0800, 16'h5555};
        rst = 1'b1; en = 1'b0; run = 1'b0; s_valid = 1'b0; s_data = '0; clr_underrun = 1'b0;
        cycle();
        cycle();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pdm", 32'(pdm_out), 32'd0);
        check("rst_valid", 32'(pdm_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Idle mid-scale pattern.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("idle_bit", 32'(pdm_out), 32'(i % 2));
            check("idle_busy", 32'(busy), 32'd0);
        end

        // 3/4 density.
        do_reset();
        push(16'h4000);
        run = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("d34_bit", 32'(pdm_out), 32'(pat[i % 4]));
            check("d34_busy", 32'(busy), 32'd1);
        end

        // Full-scale negative over two frames.
        do_reset();
        push(16'h8000);
        push(16'h8000);
        check("fs_level0", 32'(fifo_level), 32'd2);
        run = 1'b1; en = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            cycle();
            check("fs_bit", 32'(pdm_out), 32'd0);
            if (t == 1 || t == 10) check("fs_level1", 32'(fifo_level), 32'd1);
            if (t == 11) check("fs_level2", 32'(fifo_level), 32'd0);
        end

        // Underrun, clear, and stop at frame end.
        do_reset();
        push(16'h1234);
        run = 1'b1; en = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            cycle();
            if (t == 9) check("ur_before", 32'(underrun), 32'd0);
            if (t == 10) check("ur_set", 32'(underrun), 32'd1);
        end
        en = 1'b0; clr_underrun = 1'b1;
        cycle();
        clr_underrun = 1'b0;
        check("ur_clear", 32'(underrun), 32'd0);
        en = 1'b1; run = 1'b0;
        for (int t = 11; t <= 20; t++) begin
            cycle();
            if (t == 19) check("ur_busy_hold", 32'(busy), 32'd1);
            if (t == 20) check("ur_busy_drop", 32'(busy), 32'd0);
        end

        // Full FIFO then drain in push order.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = vals[k];
            cycle();
            check("ff_level", 32'(fifo_level), 32'((k + 1 < DEPTH) ? k + 1 : DEPTH));
            check("ff_ready", 32'(s_ready), 32'(k + 1 < DEPTH));
        end
        s_valid = 1'b0;
        run = 1'b1; en = 1'b1;
        for (int i = 0; i < 45; i++) cycle();

        // Reset mid-frame with samples queued.
        do_reset();
        for (int k = 0; k < 4; k++) push(vals[k]);
        run = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("mr_queued", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        cycle();
        check("mr_level", 32'(fifo_level), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_pdm", 32'(pdm_out), 32'd0);
        rst = 1'b0; run = 1'b0;
        cycle();
        check("mr_idle0", 32'(pdm_out), 32'd0);
        cycle();
        check("mr_idle1", 32'(pdm_out), 32'd1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) run = ~run;
            s_valid = $urandom_range(0, 1) == 1;
            s_data = N'($urandom);
            clr_underrun = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_modulator.md
PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 The block SHALL have parameter N, default 16: PCM sample width (two's complement).
REQ-002 The block SHALL have parameter R, default 10: oversampling ratio, i.e. PDM bits per PCM sample, R >= 2.
REQ-003 The block SHALL have parameter DEPTH, default 4: input FIFO entries, power of 2, >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit: clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port en, input, 1 bit: PDM bit tick; one PDM bit is produced per cycle with en=1.
REQ-007 The block SHALL have port run, input, 1 bit: level request to play samples.
REQ-008 The block SHALL have port s_data, input, N bits: signed PCM sample.
REQ-009 The block SHALL have port s_valid, input, 1 bit: s_data valid.
REQ-010 The block SHALL have port s_ready, output, 1 bit: FIFO can accept a sample.
REQ-011 The block SHALL have port pdm_out, output, 1 bit: registered PDM bit.
REQ-012 The block SHALL have port pdm_valid, output, 1 bit: one-cycle pulse when pdm_out is updated.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-014 The block SHALL have port underrun, output, 1 bit: sticky flag, set when a sample was due and the FIFO was empty.
REQ-015 The block SHALL have port clr_underrun, input, 1 bit: clears underrun.
REQ-016 The block SHALL have port fifo_level, output, clog2(DEPTH)+1 bits: number of FIFO entries.

Function
REQ-017 Input push SHALL occur on a cycle where s_valid=1 and s_ready=1; s_ready SHALL equal (fifo_level != DEPTH); s_data is ignored while s_ready=0.
REQ-018 The FIFO SHALL have no bypass: a sample pushed in cycle t SHALL be poppable at the earliest in cycle t+1; push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 The IDLE->RUN transition SHALL occur on a cycle with run=1, en=1, fifo_level>0; that tick pops the head into cur_sample, sets phase=0, and modulates the popped sample.
REQ-021 In RUN, each en tick SHALL advance phase 0..R-1 with wrap-around; on a tick with phase==R-1, the next tick's sample is selected as follows:
  - run=0: go to IDLE; no pop
  - run=1 and FIFO non-empty: pop into cur_sample
  - run=1 and FIFO empty: set underrun, keep cur_sample (hold), stay in RUN
REQ-022 Deasserting run mid-frame SHALL NOT truncate the frame; the transition to IDLE occurs only at the phase==R-1 tick.
REQ-023 Modulator input u SHALL be N-bit unsigned: u = sample with MSB inverted in RUN, u = 2^(N-1) (mid-scale) in IDLE.
REQ-024 The accumulator acc SHALL be N bits, updated only on en ticks as {carry, acc} <= acc + u, where the sum is N+1 bits and carry is its MSB.
REQ-025 On each en tick, pdm_out SHALL be loaded with carry and pdm_valid SHALL be 1 in the following cycle; with en=0, pdm_out, acc and phase SHALL be held and pdm_valid=0.
REQ-026 The ones density SHALL be u/2^N: full-scale negative (0x8000) gives all zeros; IDLE gives an alternating 0,1 pattern.
REQ-027 acc SHALL NOT be cleared on RUN/IDLE transitions.
REQ-028 clr_underrun SHALL clear underrun, except that a simultaneous set SHALL take priority.
REQ-029 en=0 SHALL NOT block FIFO pushes.

Reset
REQ-030 With rst=1 the block SHALL set state=IDLE, acc=0, phase=0, cur_sample=0, FIFO emptied (fifo_level=0), pdm_out=0, pdm_valid=0, underrun=0, busy=0, s_ready=1; reset mid-operation SHALL discard all queued samples.

Verification
REQ-031 The bench SHALL cover idle pattern: run=0, en=1 continuous after reset -> pdm_out sequence 0,1,0,1,... and busy=0.
REQ-032 The bench SHALL cover a 3/4 density case: push 0x4000, run=1, en=1 -> first 4 bits 0,1,1,1 repeating; busy=1 from the tick after the pop.
REQ-033 The bench SHALL cover full-scale negative: push 0x8000 x2, R=10 -> 20 zero bits; fifo_level steps 2->1 at the first tick and 1->0 at the 11th tick.
REQ-034 The bench SHALL cover underrun: push 1 sample, run=1 -> at tick R (phase 9) underrun=1 and the sample is held; clr_underrun=1 clears it; run=0 -> IDLE at the next phase==R-1 tick.
REQ-035 The bench SHALL cover full FIFO: 5 pushes with run=0 -> 4 accepted, s_ready=0 after the 4th, fifo_level=4, 5th push ignored; then run=1 -> the popped values match push order.
REQ-036 The bench SHALL cover reset mid-frame: rst=1 at phase 5 with 3 queued -> next cycle fifo_level=0, busy=0, pdm_out=0, and the idle pattern restarts with 0.
